// File: rtl/acc_cpu_pkg.sv
// Shared types for the parametrised accumulator CPU: opcodes, FSM states and ALU operations.
`timescale 1ns/1ps
package acc_cpu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDM = 4'h2,
    OP_STM = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_NOT = 4'h9,
    OP_JMP = 4'hA,
    OP_JC  = 4'hB,
    OP_JZ  = 4'hC,
    OP_CMP = 4'hD,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_OUT = 2'd2,
    HALT     = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    ALU_PASS_B = 3'd0,
    ALU_ADD    = 3'd1,
    ALU_SUB    = 3'd2,
    ALU_AND    = 3'd3,
    ALU_OR     = 3'd4,
    ALU_XOR    = 3'd5,
    ALU_NOT    = 3'd6
  } alu_op_e;

  // CMP shares SUB so its carry/zero come straight from the subtractor.
  function automatic alu_op_e alu_op_of(input opcode_e op);
    case (op)
      OP_ADD:          return ALU_ADD;
      OP_SUB, OP_CMP:  return ALU_SUB;
      OP_AND:          return ALU_AND;
      OP_OR:           return ALU_OR;
      OP_XOR:          return ALU_XOR;
      OP_NOT:          return ALU_NOT;
      default:         return ALU_PASS_B;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_core_if.sv
// Program-fetch and output-port bundle between the core (core modport) and its environment (env modport).
`timescale 1ns/1ps
interface acc_cpu_core_if
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]       prog_addr;
  logic [OPC_W+ADDR_W-1:0] prog_data;
  logic [DATA_W-1:0]       out_data;
  logic                    out_valid;
  logic                    out_ready;

  // Output handshake: a word moves on a rising clk edge where out_valid && out_ready;
  // once raised, out_valid stays high and out_data stays stable until that edge.
  modport core (
    output prog_addr,
    input  prog_data,
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport env (
    input  prog_addr,
    output prog_data,
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: pass-through, add with carry, subtract with no-borrow flag, and bitwise ops.
`timescale 1ns/1ps
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] m_i,
  input  alu_op_e           alu_op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              carry_out_o,
  output logic              zero_out_o
);

  logic [DATA_W:0] sum;
  assign sum = {1'b0, acc_i} + {1'b0, m_i};

  always_comb begin
    result_o    = m_i;
    carry_out_o = 1'b0;
    case (alu_op_i)
      ALU_ADD: {carry_out_o, result_o} = sum;
      ALU_SUB: begin
        result_o    = acc_i - m_i;
        carry_out_o = (acc_i >= m_i);
      end
      ALU_AND: result_o = acc_i & m_i;
      ALU_OR:  result_o = acc_i | m_i;
      ALU_XOR: result_o = acc_i ^ m_i;
      ALU_NOT: result_o = ~acc_i;
      default: result_o = m_i;
    endcase
    zero_out_o = (result_o == '0);
  end

endmodule

// File: rtl/acc_cpu_core.sv
// Accumulator CPU core: PC, flags, data RAM and IDLE/RUN/WAIT_OUT/HALT FSM.
// Define ACC_CPU_SINGLE_STEP_EN to add the synchronised single-step input `step`.
`timescale 1ns/1ps
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
`ifdef ACC_CPU_SINGLE_STEP_EN
  input  logic              step,
`endif
  acc_cpu_core_if.core      bus,
  output logic              halted,
  output logic [DATA_W-1:0] acc,
  output logic              carry,
  output logic              zero,
  output state_e            state_o
);

  localparam int IW = OPC_W + ADDR_W;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] acc_q, out_data_q;
  logic              carry_q, zero_q, out_valid_q, halted_q;
  logic [DATA_W-1:0] ram_q [2**ADDR_W];

  opcode_e           opc;
  logic [ADDR_W-1:0] a, pc_inc;
  logic [DATA_W-1:0] m, alu_b, alu_res;
  logic              alu_c, alu_z, step_ok, exec;

  assign opc    = opcode_e'(bus.prog_data[IW-1:ADDR_W]);
  assign a      = bus.prog_data[ADDR_W-1:0];
  assign m      = ram_q[a];
  assign alu_b  = (opc == OP_LDI) ? DATA_W'(a) : m;
  assign pc_inc = pc_q + ADDR_W'(1);

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .acc_i       (acc_q),
    .m_i         (alu_b),
    .alu_op_i    (alu_op_of(opc)),
    .result_o    (alu_res),
    .carry_out_o (alu_c),
    .zero_out_o  (alu_z)
  );

`ifdef ACC_CPU_SINGLE_STEP_EN
  logic [1:0] step_sync_q;
  logic       step_prev_q, step_pend_q;

  // A detected rising edge arms one pending instruction; executing it disarms.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_sync_q <= 2'b00;
      step_prev_q <= 1'b0;
      step_pend_q <= 1'b0;
    end else begin
      step_sync_q <= {step_sync_q[0], step};
      step_prev_q <= step_sync_q[1];
      step_pend_q <= (step_sync_q[1] & ~step_prev_q) | (step_pend_q & ~exec);
    end
  end
  assign step_ok = step_pend_q;
`else
  assign step_ok = 1'b1;
`endif

  // IDLE executes the first instruction in the same cycle it moves to RUN.
  assign exec = run && step_ok && ((state_q == IDLE) || (state_q == RUN));

  always_ff @(posedge clk) begin
    if (!rst && exec && (opc == OP_STM)) ram_q[a] <= acc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (run) state_q <= RUN;
          if (exec) begin
            pc_q <= pc_inc;
            case (opc)
              OP_LDI, OP_LDM, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                acc_q  <= alu_res;
                zero_q <= alu_z;
              end
              OP_ADD, OP_SUB: begin
                acc_q   <= alu_res;
                zero_q  <= alu_z;
                carry_q <= alu_c;
              end
              OP_CMP: begin
                carry_q <= alu_c;
                zero_q  <= alu_z;
              end
              OP_JMP: pc_q <= a;
              OP_JC:  if (carry_q) pc_q <= a;
              OP_JZ:  if (zero_q) pc_q <= a;
              OP_OUT: begin
                out_data_q  <= acc_q;
                out_valid_q <= 1'b1;
                state_q     <= WAIT_OUT;
              end
              OP_HLT: begin
                pc_q     <= pc_q;
                halted_q <= 1'b1;
                state_q  <= HALT;
              end
              default: ;
            endcase
          end
        end
        WAIT_OUT: begin
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= RUN;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.prog_addr = pc_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign halted        = halted_q;
  assign acc           = acc_q;
  assign carry         = carry_q;
  assign zero          = zero_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core: arithmetic, jumps, output stall, halt/wrap and async reset.
`timescale 1ns/1ps
module tb_acc_cpu_core;
  import acc_cpu_pkg::*;

  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst, run;
  logic          halted, carry, zero;
  logic [DW-1:0] acc;
  state_e        state_o;
  logic [7:0]    prog [16];
  logic [DW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            n_xfers  = 0;

  acc_cpu_core_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  assign bus.prog_data = prog[bus.prog_addr];

  always #5 clk = ~clk;

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .bus     (bus),
    .halted  (halted),
    .acc     (acc),
    .carry   (carry),
    .zero    (zero),
    .state_o (state_o)
  );

  function automatic logic [7:0] ins(input opcode_e op, input int a);
    return {op, 4'(a)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard pop happens just before the edge that completes a handshake.
  task automatic tick(input int n);
    repeat (n) begin
      if (bus.out_valid && bus.out_ready) begin
        n_xfers++;
        if (exp_q.size() == 0) check("xfer_unexpected", 32'(bus.out_data), 32'hFFFF_FFFF);
        else check("out_data_xfer", 32'(bus.out_data), 32'(exp_q.pop_front()));
      end
      @(negedge clk);
    end
  endtask

  task automatic load_nops();
    for (int i = 0; i < 16; i++) prog[i] = ins(OP_NOP, 0);
  endtask

  task automatic do_reset();
    run = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  int e_acc [12];
  int e_c   [12];
  int e_z   [12];
  int e_pc  [12];

  initial begin
    // Reset and idle
    rst = 1'b1;
    run = 1'b0;
    bus.out_ready = 1'b0;
    load_nops();
    #1;
    check("rst_pc", 32'(bus.prog_addr), 0);
    check("rst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;
    tick(5);
    check("idle_pc", 32'(bus.prog_addr), 0);
    check("idle_acc", 32'(acc), 0);
    check("idle_valid", 32'(bus.out_valid), 0);
    check("idle_halted", 32'(halted), 0);
    check("idle_flags", 32'({carry, zero}), 0);
    check("idle_state", 32'(state_o), 32'(IDLE));
    run = 1'b1;
    tick(1);
    check("run_pc", 32'(bus.prog_addr), 1);
    check("run_state", 32'(state_o), 32'(RUN));

    // Arithmetic and logic
    do_reset();
    load_nops();
    prog[0]  = ins(OP_LDI, 9);  prog[1]  = ins(OP_STM, 3);
    prog[2]  = ins(OP_LDI, 8);  prog[3]  = ins(OP_ADD, 3);
    prog[4]  = ins(OP_SUB, 3);  prog[5]  = ins(OP_XOR, 3);
    prog[6]  = ins(OP_NOT, 0);  prog[7]  = ins(OP_AND, 3);
    prog[8]  = ins(OP_OR, 3);   prog[9]  = ins(OP_LDM, 3);
    prog[10] = ins(OP_LDI, 0);  prog[11] = ins(OP_HLT, 0);
    e_acc = '{9, 9, 8, 1, 8, 1, 14, 8, 9, 9, 0, 0};
    e_c   = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    e_z   = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    e_pc  = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 11};
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check($sformatf("alu_acc_%0d", i), 32'(acc), 32'(e_acc[i]));
      check($sformatf("alu_carry_%0d", i), 32'(carry), 32'(e_c[i]));
      check($sformatf("alu_zero_%0d", i), 32'(zero), 32'(e_z[i]));
      check($sformatf("alu_pc_%0d", i), 32'(bus.prog_addr), 32'(e_pc[i]));
    end
    check("alu_halted", 32'(halted), 1);

    // Conditional jumps and self-loop
    do_reset();
    load_nops();
    prog[0]  = ins(OP_LDI, 5);  prog[1]  = ins(OP_STM, 0);
    prog[2]  = ins(OP_CMP, 0);  prog[3]  = ins(OP_JZ, 7);
    prog[7]  = ins(OP_JC, 9);   prog[9]  = ins(OP_LDI, 3);
    prog[10] = ins(OP_CMP, 0);  prog[11] = ins(OP_JC, 2);
    prog[12] = ins(OP_JZ, 2);   prog[13] = ins(OP_JMP, 13);
    e_acc = '{5, 5, 5, 5, 5, 3, 3, 3, 3, 3, 3, 3};
    e_c   = '{0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};
    e_z   = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    e_pc  = '{1, 2, 3, 7, 9, 10, 11, 12, 13, 13, 13, 13};
    run = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      check($sformatf("jmp_acc_%0d", i), 32'(acc), 32'(e_acc[i]));
      check($sformatf("jmp_carry_%0d", i), 32'(carry), 32'(e_c[i]));
      check($sformatf("jmp_zero_%0d", i), 32'(zero), 32'(e_z[i]));
      check($sformatf("jmp_pc_%0d", i), 32'(bus.prog_addr), 32'(e_pc[i]));
    end

    // Output stall and handshake
    do_reset();
    load_nops();
    prog[0] = ins(OP_LDI, 10); prog[1] = ins(OP_OUT, 0);
    prog[2] = ins(OP_LDI, 4);  prog[3] = ins(OP_OUT, 0);
    prog[4] = ins(OP_HLT, 0);
    exp_q.push_back(4'hA);
    exp_q.push_back(4'h4);
    run = 1'b1;
    tick(1);
    check("out_lda", 32'(acc), 32'hA);
    tick(1);
    check("out_valid_rise", 32'(bus.out_valid), 1);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check($sformatf("stall_valid_%0d", i), 32'(bus.out_valid), 1);
      check($sformatf("stall_data_%0d", i), 32'(bus.out_data), 32'hA);
      check($sformatf("stall_pc_%0d", i), 32'(bus.prog_addr), 2);
      check($sformatf("stall_state_%0d", i), 32'(state_o), 32'(WAIT_OUT));
    end
    bus.out_ready = 1'b1;
    tick(1);
    check("xfer1_count", 32'(n_xfers), 1);
    check("xfer1_valid", 32'(bus.out_valid), 0);
    check("xfer1_state", 32'(state_o), 32'(RUN));
    check("xfer1_pc", 32'(bus.prog_addr), 2);
    tick(1);
    check("resume_acc", 32'(acc), 4);
    check("resume_pc", 32'(bus.prog_addr), 3);
    tick(1);
    check("out2_valid", 32'(bus.out_valid), 1);
    check("out2_pc", 32'(bus.prog_addr), 4);
    tick(1);
    check("xfer2_count", 32'(n_xfers), 2);
    check("xfer2_valid", 32'(bus.out_valid), 0);
    tick(1);
    check("out_halted", 32'(halted), 1);
    check("out_halt_valid", 32'(bus.out_valid), 0);
    check("out_q_empty", 32'(exp_q.size()), 0);

    // PC wrap, halt, reset out of HALT
    do_reset();
    load_nops();
    run = 1'b1;
    tick(15);
    check("wrap_pc15", 32'(bus.prog_addr), 15);
    tick(1);
    check("wrap_pc0", 32'(bus.prog_addr), 0);
    prog[1] = ins(OP_HLT, 0);
    tick(2);
    check("hlt_halted", 32'(halted), 1);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check($sformatf("hlt_pc_%0d", i), 32'(bus.prog_addr), 1);
      check($sformatf("hlt_state_%0d", i), 32'(state_o), 32'(HALT));
    end
    #2 rst = 1'b1;
    #1;
    check("hlt_rst_halted", 32'(halted), 0);
    check("hlt_rst_pc", 32'(bus.prog_addr), 0);
    check("hlt_rst_state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    rst = 1'b0;

    // Async reset during WAIT_OUT drops the pending word
    run = 1'b0;
    load_nops();
    prog[0] = ins(OP_LDI, 7); prog[1] = ins(OP_OUT, 0);
    exp_q.push_back(4'h7);
    bus.out_ready = 1'b0;
    run = 1'b1;
    tick(2);
    check("wo_state", 32'(state_o), 32'(WAIT_OUT));
    check("wo_data", 32'(bus.out_data), 7);
    #2 rst = 1'b1;
    #1;
    check("wo_rst_valid", 32'(bus.out_valid), 0);
    check("wo_rst_state", 32'(state_o), 32'(IDLE));
    check("wo_rst_data", 32'(bus.out_data), 0);
    check("wo_rst_acc", 32'(acc), 0);
    check("wo_rst_pc", 32'(bus.prog_addr), 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    bus.out_ready = 1'b1;
    tick(3);
    check("wo_post_valid", 32'(bus.out_valid), 0);
    check("wo_post_xfers", 32'(n_xfers), 2);
    check("wo_post_state", 32'(state_o), 32'(IDLE));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
